// File: rtl/dcache_setassoc.sv
// N-way set-associative write-back data cache with age-based LRU, one outstanding miss,
// and per-thread stall bits that are cleared when the refill lands.
module dcache_setassoc #(
  parameter int N_WAYS     = 2,
  parameter int N_SETS     = 4,
  parameter int LINE_BYTES = 16,
  parameter int N_THREADS  = 4,
  parameter int ADDR_W     = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(N_THREADS)-1:0] thread,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         isvalid,
  input  logic                         flag_mem,
  input  logic                         dtlb_miss,
  output logic                         miss,
  output logic [31:0]                  data,
  output logic [N_THREADS-1:0]         stalled,
  input  logic                         store_en,
  input  logic                         store_isbyte,
  input  logic [ADDR_W-1:0]            store_addr,
  input  logic [31:0]                  store_data,
  output logic                         store_ok,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [LINE_BYTES*8-1:0]      mem_req_wline,
  input  logic                         mem_rec_en,
  input  logic [ADDR_W-1:0]            mem_rec_addr,
  input  logic [LINE_BYTES*8-1:0]      mem_rec_line
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(N_SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = $clog2(N_WAYS);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef logic [N_WAYS-1:0][WAY_W-1:0] ages_t;
  typedef enum logic [1:0] {IDLE, WB_REQ, RD_REQ, WAIT_FILL} state_t;

  logic [N_WAYS-1:0] valid_q [N_SETS];
  logic [N_WAYS-1:0] dirty_q [N_SETS];
  logic [TAG_W-1:0]  tag_q   [N_SETS][N_WAYS];
  logic [LINE_W-1:0] line_q  [N_SETS][N_WAYS];
  ages_t             age_q   [N_SETS];
  ages_t             age_d   [N_SETS];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr, wb_addr;
  logic [WAY_W-1:0]  pend_way;
  logic [LINE_W-1:0] wb_line;

  // load-side lookup
  logic [IDX_W-1:0]   l_idx;
  logic [TAG_W-1:0]   l_tag;
  logic [OFF_W-3:0]   l_wsel;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, v_way;
  logic [LINE_W-1:0]  l_line;
  // store-side lookup
  logic [IDX_W-1:0]   s_idx;
  logic [TAG_W-1:0]   s_tag;
  logic [OFF_W-1:0]   s_off;
  logic               s_hit;
  logic [WAY_W-1:0]   s_way;
  logic [IDX_W-1:0]   pend_idx;

  logic q_miss, load_acc, start_miss, fill_hit, s_guard;
  logic unused_ok;

  assign l_idx    = paddr[OFF_W+IDX_W-1:OFF_W];
  assign l_tag    = paddr[ADDR_W-1:OFF_W+IDX_W];
  assign l_wsel   = paddr[OFF_W-1:2];
  assign s_idx    = store_addr[OFF_W+IDX_W-1:OFF_W];
  assign s_tag    = store_addr[ADDR_W-1:OFF_W+IDX_W];
  assign s_off    = store_addr[OFF_W-1:0];
  assign pend_idx = pend_addr[OFF_W+IDX_W-1:OFF_W];
  assign unused_ok = ^paddr[1:0];

  always_comb begin
    hit = 1'b0;  hit_way = '0;
    s_hit = 1'b0; s_way = '0;
    v_way = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
        hit = 1'b1; hit_way = WAY_W'(w);
      end
      if (valid_q[s_idx][w] && tag_q[s_idx][w] == s_tag) begin
        s_hit = 1'b1; s_way = WAY_W'(w);
      end
      if (age_q[l_idx][w] == WAY_W'(N_WAYS - 1)) v_way = WAY_W'(w);
    end
    // descending scan so the lowest-index invalid way wins over the LRU way
    for (int w = N_WAYS - 1; w >= 0; w--)
      if (!valid_q[l_idx][w]) v_way = WAY_W'(w);
  end

  assign l_line     = line_q[l_idx][hit_way];
  assign miss       = ~hit | dtlb_miss;
  assign data       = miss ? 32'd0 : l_line[32*l_wsel +: 32];
  assign q_miss     = flag_mem & isvalid & ~dtlb_miss & ~hit;
  assign load_acc   = flag_mem & isvalid & ~dtlb_miss & hit;
  assign start_miss = (state_q == IDLE) & q_miss;
  assign fill_hit   = (state_q == WAIT_FILL) & mem_rec_en &
                      ((mem_rec_addr & ~OFF_MASK) == pend_addr);

  // the victim way of the pending set must not be modified while the miss is in flight
  assign s_guard  = (state_q != IDLE) && (s_idx == pend_idx) && (s_way == pend_way);
  assign store_ok = store_en & s_hit & ~s_guard;

  assign mem_req_valid = (state_q == WB_REQ) || (state_q == RD_REQ);
  assign mem_req_we    = (state_q == WB_REQ);
  assign mem_req_addr  = mem_req_we ? wb_addr : pend_addr;
  assign mem_req_wline = wb_line;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_miss)
                   state_d = (valid_q[l_idx][v_way] && dirty_q[l_idx][v_way]) ? WB_REQ : RD_REQ;
      WB_REQ:    if (mem_req_ready) state_d = RD_REQ;
      RD_REQ:    if (mem_req_ready) state_d = WAIT_FILL;
      WAIT_FILL: if (fill_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] way);
    touch = a;
    for (int w = 0; w < N_WAYS; w++)
      if (a[w] < a[way]) touch[w] = a[w] + 1'b1;
    touch[way] = '0;
  endfunction

  always_comb begin
    age_d = age_q;
    if (load_acc) age_d[l_idx]    = touch(age_d[l_idx], hit_way);
    if (store_ok) age_d[s_idx]    = touch(age_d[s_idx], s_way);
    if (fill_hit) age_d[pend_idx] = touch(age_d[pend_idx], pend_way);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < N_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
      stalled <= '0;
    end else begin
      age_q <= age_d;
      if (store_ok) dirty_q[s_idx][s_way] <= 1'b1;
      if (fill_hit) begin
        valid_q[pend_idx][pend_way] <= 1'b1;
        dirty_q[pend_idx][pend_way] <= 1'b0;
        stalled <= '0;
      end
      // later assignment: a new miss beats the wake-up on the same edge
      if (q_miss) stalled[thread] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store_ok) begin
      if (store_isbyte) line_q[s_idx][s_way][8*s_off +: 8] <= store_data[7:0];
      else              line_q[s_idx][s_way][32*s_off[OFF_W-1:2] +: 32] <= store_data;
    end
    if (fill_hit) begin
      tag_q[pend_idx][pend_way]  <= pend_addr[ADDR_W-1:OFF_W+IDX_W];
      line_q[pend_idx][pend_way] <= mem_rec_line;
    end
    if (start_miss) begin
      pend_addr <= paddr & ~OFF_MASK;
      pend_way  <= v_way;
      wb_addr   <= {tag_q[l_idx][v_way], l_idx, {OFF_W{1'b0}}};
      wb_line   <= line_q[l_idx][v_way];
    end
  end

endmodule

// File: tb/tb_dcache_setassoc.sv
// Bench for dcache_setassoc: lookup vector table plus hand-written miss/evict/store sequences,
// with memory requests checked against an expected-request queue.
module tb_dcache_setassoc;
  logic         clk, rst;
  logic [1:0]   thread;
  logic [19:0]  paddr, store_addr, mem_req_addr, mem_rec_addr;
  logic         isvalid, flag_mem, dtlb_miss, miss, store_en, store_isbyte, store_ok;
  logic [31:0]  data, store_data;
  logic [3:0]   stalled;
  logic         mem_req_valid, mem_req_ready, mem_req_we, mem_rec_en;
  logic [127:0] mem_req_wline, mem_rec_line;

  dcache_setassoc dut (
    .clk(clk), .rst(rst), .thread(thread), .paddr(paddr), .isvalid(isvalid),
    .flag_mem(flag_mem), .dtlb_miss(dtlb_miss), .miss(miss), .data(data), .stalled(stalled),
    .store_en(store_en), .store_isbyte(store_isbyte), .store_addr(store_addr),
    .store_data(store_data), .store_ok(store_ok), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wline(mem_req_wline), .mem_rec_en(mem_rec_en), .mem_rec_addr(mem_rec_addr),
    .mem_rec_line(mem_rec_line));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LA = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] LB = {32'h40, 32'h30, 32'h20, 32'h10};
  localparam logic [127:0] LC = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] LD = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
  localparam logic [127:0] LE = {32'hE3, 32'hE2, 32'hE1, 32'hE0};

  typedef struct { logic we; logic [19:0] addr; logic [31:0] w1; } req_t;
  typedef struct { logic [19:0] a; logic dt; logic exp_miss; logic [31:0] exp_data; } vec_t;

  req_t exp_q[$];
  vec_t tbl[7];
  int   n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard: each accepted memory request is checked against the oldest expectation
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_req: got addr %0h we %0b expected no request", mem_req_addr, mem_req_we);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk("req_we", mem_req_we, e.we);
        chk("req_addr", mem_req_addr, e.addr);
        if (e.we) chk("req_wline_w1", mem_req_wline[63:32], e.w1);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    isvalid = 0; flag_mem = 0; dtlb_miss = 0; store_en = 0; store_isbyte = 0;
  endtask

  task automatic look(input logic [1:0] th, input logic [19:0] a, input logic fm);
    thread = th; paddr = a; isvalid = 1; flag_mem = fm; #1;
  endtask

  task automatic store(input logic [19:0] a, input logic [31:0] d, input logic byt);
    store_en = 1; store_addr = a; store_data = d; store_isbyte = byt; #1;
  endtask

  task automatic push(input logic we, input logic [19:0] a, input logic [31:0] w1);
    exp_q.push_back('{we, a, w1});
  endtask

  // grant requests until the line read is accepted
  task automatic wait_rd;
    logic ok;
    ok = 0;
    mem_req_ready = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_req_valid && !mem_req_we) ok = 1;
      tick;
    end
    mem_req_ready = 0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL rd_req_timeout: got no read request expected one within 20 cycles");
    end
  endtask

  task automatic fill(input logic [19:0] a, input logic [127:0] l);
    mem_rec_en = 1; mem_rec_addr = a; mem_rec_line = l;
    tick;
    mem_rec_en = 0;
  endtask

  initial begin
    tbl[0] = '{20'h00040, 1'b0, 1'b0, 32'd1};
    tbl[1] = '{20'h0004C, 1'b0, 1'b0, 32'd4};
    tbl[2] = '{20'h00088, 1'b0, 1'b0, 32'h30};
    tbl[3] = '{20'h00084, 1'b1, 1'b1, 32'd0};
    tbl[4] = '{20'h000C0, 1'b0, 1'b1, 32'd0};
    tbl[5] = '{20'h00050, 1'b0, 1'b1, 32'd0};
    tbl[6] = '{20'h80040, 1'b0, 1'b1, 32'd0};

    rst = 1; idle_in; mem_req_ready = 0; mem_rec_en = 0; thread = 0; paddr = 0;
    store_addr = 0; store_data = 0; mem_rec_addr = 0; mem_rec_line = 0;
    repeat (2) tick;
    rst = 0;
    chk("rst_stalled", stalled, 4'b0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_req_we", mem_req_we, 1'b0);
    look(0, 20'h00040, 0);
    chk("rst_cold_lookup", miss, 1'b1);
    idle_in;

    // cold miss, refill, replay
    look(1, 20'h00040, 1);
    chk("cold_miss", miss, 1'b1);
    chk("cold_data", data, 32'd0);
    push(0, 20'h00040, 0);
    tick; idle_in;
    chk("cold_stall", stalled, 4'b0010);
    chk("cold_req_valid", mem_req_valid, 1'b1);
    chk("cold_req_addr", mem_req_addr, 20'h00040);
    chk("cold_req_we", mem_req_we, 1'b0);
    wait_rd;
    chk("valid_drop", mem_req_valid, 1'b0);
    fill(20'h00040, LA);
    chk("fill_unstall", stalled, 4'b0);
    look(1, 20'h00044, 1);
    chk("replay_hit", miss, 1'b0);
    chk("replay_data", data, 32'd2);
    tick; idle_in;

    // second line into way 1 of set 0
    look(0, 20'h00080, 1);
    push(0, 20'h00080, 0);
    tick; idle_in;
    wait_rd;
    fill(20'h00080, LB);

    foreach (tbl[i]) begin
      dtlb_miss = tbl[i].dt;
      look(0, tbl[i].a, 0);
      chk($sformatf("tbl%0d_miss", i), miss, tbl[i].exp_miss);
      chk($sformatf("tbl%0d_data", i), data, tbl[i].exp_data);
      idle_in;
    end

    // stores: word, byte merge, same-cycle load sees old data
    store(20'h00044, 32'h11223344, 0);
    chk("st_word_ok", store_ok, 1'b1);
    tick; idle_in;
    store(20'h00047, 32'h000000AB, 1);
    chk("st_byte_ok", store_ok, 1'b1);
    tick; idle_in;
    look(0, 20'h00044, 0);
    chk("st_byte_data", data, 32'hAB223344);
    store(20'h00044, 32'hDEADBEEF, 0);
    chk("st_dead_ok", store_ok, 1'b1);
    chk("st_pre_data", data, 32'hAB223344);
    tick;
    chk("st_post_data", data, 32'hDEADBEEF);
    idle_in;
    store(20'h01000, 32'h55, 0);
    chk("st_uncached_ok", store_ok, 1'b0);
    tick; idle_in;
    look(0, 20'h01000, 0);
    chk("st_uncached_miss", miss, 1'b1);
    look(0, 20'h00040, 0);
    chk("st_uncached_nochg", data, 32'd1);
    idle_in;

    // make way 1 MRU, then evict dirty way 0
    look(0, 20'h00080, 1);
    chk("mru_hit", miss, 1'b0);
    tick; idle_in;
    look(0, 20'h000C0, 1);
    chk("evict_miss", miss, 1'b1);
    push(1, 20'h00040, 32'hDEADBEEF);
    push(0, 20'h000C0, 0);
    tick; idle_in;
    for (int i = 0; i < 3; i++) begin
      store(20'h00048, 32'h99, 0);
      chk("victim_store_blk", store_ok, 1'b0);
      look(0, 20'h00044, 0);
      chk("victim_still_hit", miss, 1'b0);
      chk("wb_valid_hold", mem_req_valid, 1'b1);
      chk("wb_we_hold", mem_req_we, 1'b1);
      chk("wb_addr_hold", mem_req_addr, 20'h00040);
      chk("wb_w1_hold", mem_req_wline[63:32], 32'hDEADBEEF);
      tick; idle_in;
    end
    look(0, 20'h00048, 0);
    chk("victim_unchanged", data, 32'd3);
    idle_in;
    wait_rd;
    fill(20'h000C0, LC);
    look(0, 20'h00080, 0);
    chk("keep_hit", miss, 1'b0);
    chk("keep_data", data, 32'h10);
    look(0, 20'h000C4, 0);
    chk("new_data", data, 32'hC1);
    look(0, 20'h00040, 0);
    chk("evicted_miss", miss, 1'b1);
    idle_in;

    // two threads miss; only the first reaches memory
    chk("sb_empty", exp_q.size(), 0);
    look(0, 20'h00100, 1);
    push(0, 20'h00100, 0);
    tick;
    look(2, 20'h00210, 1);
    tick; idle_in;
    chk("two_stall", stalled, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      chk("rd_valid_hold", mem_req_valid, 1'b1);
      chk("rd_addr_hold", mem_req_addr, 20'h00100);
      tick;
    end
    wait_rd;
    fill(20'h00500, LE);
    chk("nonmatch_ignored", stalled, 4'b0101);
    fill(20'h00100, LD);
    chk("two_unstall", stalled, 4'b0);
    look(2, 20'h00210, 1);
    chk("remiss", miss, 1'b1);
    push(0, 20'h00210, 0);
    tick; idle_in;
    chk("remiss_stall", stalled, 4'b0100);
    chk("remiss_addr", mem_req_addr, 20'h00210);
    wait_rd;
    look(2, 20'h00300, 1);
    fill(20'h00210, LE);
    idle_in;
    chk("set_beats_clear", stalled, 4'b0100);
    look(0, 20'h00214, 0);
    chk("t2_line_data", data, 32'hE1);
    idle_in;

    // reset in the middle of a miss
    look(1, 20'h00300, 1);
    push(0, 20'h00300, 0);
    tick; idle_in;
    chk("mid_req_valid", mem_req_valid, 1'b1);
    rst = 1; tick; rst = 0;
    exp_q.delete();
    chk("mid_rst_valid", mem_req_valid, 1'b0);
    chk("mid_rst_stall", stalled, 4'b0);
    fill(20'h00300, LD);
    chk("late_fill_valid", mem_req_valid, 1'b0);
    look(1, 20'h00300, 0);
    chk("late_fill_miss", miss, 1'b1);
    idle_in;
    look(1, 20'h00300, 1);
    push(0, 20'h00300, 0);
    tick; idle_in;
    chk("post_rst_req", mem_req_addr, 20'h00300);
    wait_rd;
    fill(20'h00300, LD);
    look(1, 20'h00308, 0);
    chk("post_rst_data", data, 32'hD2);
    idle_in;
    tick;
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
